// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU, loader/DMA) and the memory arbiter.
interface mem_arbiter_if;
  logic        req0;
  logic [2:0]  cmd0;
  logic [8:0]  addr0;
  logic [15:0] wdata0;
  logic        gnt0;

  logic        req1;
  logic [2:0]  cmd1;
  logic [8:0]  addr1;
  logic [15:0] wdata1;
  logic        gnt1;

  logic [2:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        err_illegal;

  // Requester side (both ports) plus observation of the RAM-facing outputs.
  modport master (
    output req0, cmd0, addr0, wdata0, req1, cmd1, addr1, wdata1,
    input  gnt0, gnt1, mem_cmd, mem_addr, mem_wdata, err_illegal
  );

  // Arbiter side.
  modport slave (
    input  req0, cmd0, addr0, wdata0, req1, cmd1, addr1, wdata1,
    output gnt0, gnt1, mem_cmd, mem_addr, mem_wdata, err_illegal
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: round-robin tie break, bounded hold with preemption,
// combinational command/address/data mux toward the RAM, sticky illegal-command flag.
module mem_arbiter #(
  parameter int unsigned MAXHOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StG0   = 2'd1,
    StG1   = 2'd2
  } state_e;

  localparam logic [3:0] HoldMax = 4'(MAXHOLD - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  hold_q, hold_d;
  logic        err_q, err_d;

  logic        granted;
  logic        legal;
  logic [2:0]  sel_cmd;
  logic [8:0]  sel_addr;
  logic [15:0] sel_wdata;

  // State, tie-break, hold counter and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  // Next-state arbitration, hold counting and tie-break bookkeeping.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.req0 && bus_io.req1) begin
          state_d = last_q ? StG0 : StG1;
        end else if (bus_io.req0) begin
          state_d = StG0;
        end else if (bus_io.req1) begin
          state_d = StG1;
        end
      end
      StG0: begin
        if (!bus_io.req0) begin
          state_d = bus_io.req1 ? StG1 : StIdle;
        end else if (bus_io.req1 && (hold_q == HoldMax)) begin
          state_d = StG1;
        end
      end
      StG1: begin
        if (!bus_io.req1) begin
          state_d = bus_io.req0 ? StG0 : StIdle;
        end else if (bus_io.req0 && (hold_q == HoldMax)) begin
          state_d = StG0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      hold_d = '0;
      if (state_d == StG0) begin
        last_d = 1'b0;
      end else if (state_d == StG1) begin
        last_d = 1'b1;
      end
    end else if (hold_q != HoldMax) begin
      hold_d = hold_q + 4'd1;
    end
  end

  // RAM-side mux: only the owning port reaches memory; illegal commands become MNONE.
  always_comb begin
    granted   = 1'b0;
    sel_cmd   = 3'b001;
    sel_addr  = '0;
    sel_wdata = '0;
    if (state_q == StG0) begin
      granted   = 1'b1;
      sel_cmd   = bus_io.cmd0;
      sel_addr  = bus_io.addr0;
      sel_wdata = bus_io.wdata0;
    end else if (state_q == StG1) begin
      granted   = 1'b1;
      sel_cmd   = bus_io.cmd1;
      sel_addr  = bus_io.addr1;
      sel_wdata = bus_io.wdata1;
    end
    legal = (sel_cmd == 3'b001) || (sel_cmd == 3'b010) || (sel_cmd == 3'b100);
    err_d = err_q | (granted & ~legal);
  end

  assign bus_io.gnt0        = (state_q == StG0);
  assign bus_io.gnt1        = (state_q == StG1);
  assign bus_io.mem_cmd     = legal ? sel_cmd : 3'b001;
  assign bus_io.mem_addr    = sel_addr;
  assign bus_io.mem_wdata   = sel_wdata;
  assign bus_io.err_illegal = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: expectations are queued as stimulus is applied
// and compared against the packed DUT outputs one time unit after each clock edge.
module tb_mem_arbiter;

  typedef logic [30:0] obs_t;  // {gnt0, gnt1, mem_cmd, mem_addr, mem_wdata, err_illegal}

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  obs_t exp_q[$];

  mem_arbiter_if bus ();

  mem_arbiter #(.MAXHOLD(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic g0, input logic g1, input logic [2:0] c,
                              input logic [8:0] a, input logic [15:0] w, input logic e);
    return {g0, g1, c, a, w, e};
  endfunction

  function automatic obs_t obs();
    return {bus.gnt0, bus.gnt1, bus.mem_cmd, bus.mem_addr, bus.mem_wdata, bus.err_illegal};
  endfunction

  // Hold reset across one edge with the given requests, release on a falling edge.
  task automatic do_reset(input logic r0, input logic r1);
    reset    = 1'b0;
    bus.req0 = r0;
    bus.req1 = r1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, g;
    bus.cmd0 = 3'b010; bus.addr0 = 9'h011; bus.wdata0 = 16'haaaa;
    bus.cmd1 = 3'b100; bus.addr1 = 9'h1f0; bus.wdata1 = 16'h5555;
    bus.req0 = 1'b1;   bus.req1 = 1'b1;
    #2 reset = 1'b0;
    exp_q.push_back(mk(0, 0, 3'b001, 9'h000, 16'h0000, 0));
    #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_async got %h exp %h", g, e); end
    exp_q.push_back(mk(0, 0, 3'b001, 9'h000, 16'h0000, 0));
    @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_held got %h exp %h", g, e); end
    @(negedge clk) reset = 1'b1;
    exp_q.push_back(mk(1, 0, 3'b010, 9'h011, 16'haaaa, 0));
    @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL tie_after_reset got %h exp %h", g, e); end
  endtask

  task automatic test_alternate();
    obs_t e, g;
    bus.cmd0 = 3'b010; bus.addr0 = 9'h005; bus.wdata0 = 16'h1234;
    bus.cmd1 = 3'b100; bus.addr1 = 9'h1ff; bus.wdata1 = 16'hbeef;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 24; i++) begin
      if (((i / 8) % 2) == 0) exp_q.push_back(mk(1, 0, 3'b010, 9'h005, 16'h1234, 0));
      else                    exp_q.push_back(mk(0, 1, 3'b100, 9'h1ff, 16'hbeef, 0));
      @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL alternate[%0d] got %h exp %h", i, g, e); end
    end
  endtask

  task automatic test_hold();
    obs_t e, g;
    bus.cmd0 = 3'b010; bus.addr0 = 9'h005; bus.wdata0 = 16'h0f0f;
    bus.cmd1 = 3'b100; bus.addr1 = 9'h1ab; bus.wdata1 = 16'hf0f0;
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(mk(1, 0, 3'b010, 9'h005, 16'h0f0f, 0));
      @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL hold[%0d] got %h exp %h", i, g, e); end
    end
    // Counter is saturated, so a new competing request preempts on the next edge.
    bus.req1 = 1'b1;
    exp_q.push_back(mk(0, 1, 3'b100, 9'h1ab, 16'hf0f0, 0));
    @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL preempt_saturated got %h exp %h", g, e); end
    bus.req1 = 1'b0;
    exp_q.push_back(mk(1, 0, 3'b010, 9'h005, 16'h0f0f, 0));
    @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL handback_g0 got %h exp %h", g, e); end
  endtask

  task automatic test_handoff();
    obs_t e, g;
    bus.cmd0 = 3'b100; bus.addr0 = 9'h022; bus.wdata0 = 16'h1111;
    bus.cmd1 = 3'b010; bus.addr1 = 9'h033; bus.wdata1 = 16'h2222;
    do_reset(1'b0, 1'b1);
    exp_q.push_back(mk(0, 1, 3'b010, 9'h033, 16'h2222, 0));
    @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL idle_to_g1 got %h exp %h", g, e); end
    bus.req0 = 1'b1;
    exp_q.push_back(mk(0, 1, 3'b010, 9'h033, 16'h2222, 0));
    @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL g1_keeps got %h exp %h", g, e); end
    bus.req1 = 1'b0;
    exp_q.push_back(mk(1, 0, 3'b100, 9'h022, 16'h1111, 0));
    @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL g1_to_g0 got %h exp %h", g, e); end
    bus.req0 = 1'b0;
    exp_q.push_back(mk(0, 0, 3'b001, 9'h000, 16'h0000, 0));
    @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL g0_to_idle got %h exp %h", g, e); end
    // Port 0 was granted last, so a tie now goes to port 1.
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    exp_q.push_back(mk(0, 1, 3'b010, 9'h033, 16'h2222, 0));
    @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL tie_last0 got %h exp %h", g, e); end
  endtask

  task automatic test_illegal();
    obs_t e, g;
    bus.cmd0 = 3'b010; bus.addr0 = 9'h044; bus.wdata0 = 16'h3333;
    bus.cmd1 = 3'b111; bus.addr1 = 9'h055; bus.wdata1 = 16'h6666;
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(1, 0, 3'b010, 9'h044, 16'h3333, 0));
      @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL nongranted_bad[%0d] got %h exp %h", i, g, e); end
    end
    bus.cmd0 = 3'b011;
    exp_q.push_back(mk(1, 0, 3'b001, 9'h044, 16'h3333, 0));
    #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL illegal_masked got %h exp %h", g, e); end
    exp_q.push_back(mk(1, 0, 3'b001, 9'h044, 16'h3333, 1));
    @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL illegal_flag got %h exp %h", g, e); end
    bus.cmd0 = 3'b010;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(1, 0, 3'b010, 9'h044, 16'h3333, 1));
      @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL illegal_sticky[%0d] got %h exp %h", i, g, e); end
    end
    reset = 1'b0;
    exp_q.push_back(mk(0, 0, 3'b001, 9'h000, 16'h0000, 0));
    #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL illegal_clear got %h exp %h", g, e); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    obs_t e, g;
    bus.cmd0 = 3'b100; bus.addr0 = 9'h066; bus.wdata0 = 16'h4444;
    bus.cmd1 = 3'b010; bus.addr1 = 9'h077; bus.wdata1 = 16'h7777;
    do_reset(1'b1, 1'b0);
    exp_q.push_back(mk(1, 0, 3'b100, 9'h066, 16'h4444, 0));
    @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL mid_g0 got %h exp %h", g, e); end
    #2 reset = 1'b0;
    exp_q.push_back(mk(0, 0, 3'b001, 9'h000, 16'h0000, 0));
    #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL mid_reset_drop got %h exp %h", g, e); end
    // Request held through release is arbitrated at the first edge with reset high.
    @(negedge clk) reset = 1'b1;
    exp_q.push_back(mk(1, 0, 3'b100, 9'h066, 16'h4444, 0));
    @(posedge clk); #1 g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL held_through_reset got %h exp %h", g, e); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    bus.req0 = 1'b0; bus.cmd0 = 3'b001; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.cmd1 = 3'b001; bus.addr1 = '0; bus.wdata1 = '0;
    test_reset();
    test_alternate();
    test_hold();
    test_handoff();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAXHOLD, default 8, max consecutive granted cycles while the other port waits; legal 1..15.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low; reset==0 forces reset state immediately, independent of clk.
REQ-004 req0  input  1  port 0 (CPU) requests memory ownership.
REQ-005 cmd0  input  3  port 0 command, one-hot: MNONE=001, MREAD=010, MWRITE=100.
REQ-006 addr0  input  9  port 0 memory address.
REQ-007 wdata0  input  16  port 0 write data.
REQ-008 gnt0  output  1  port 0 owns memory this cycle.
REQ-009 req1, cmd1, addr1, wdata1, gnt1: same widths and meanings for port 1 (loader/DMA).
REQ-010 mem_cmd  output  3  command to RAM, same one-hot encoding.
REQ-011 mem_addr  output  9  address to RAM.
REQ-012 mem_wdata  output  16  write data to RAM.
REQ-013 err_illegal  output  1  sticky flag; granted port issued a non-legal cmd.

Function
REQ-014 FSM states SHALL be IDLE, G0, G1; gnt0 SHALL be 1 exactly in G0, gnt1 exactly in G1; both decoded from the state register, never from inputs.
REQ-015 A register last (0/1) SHALL record the port most recently granted; used only to break ties.
REQ-016 IDLE: req0 only -> G0; req1 only -> G1; both -> port != last; neither -> stay IDLE.
REQ-017 G0: req0==0 -> G1 if req1 else IDLE (direct handoff, no idle cycle); G1 symmetric.
REQ-018 Hold counter (4 bit) SHALL clear on every state change and increment each cycle the state is unchanged, saturating at MAXHOLD-1.
REQ-019 In G0 with req0==1, req1==1 and counter==MAXHOLD-1, next state SHALL be G1 (preemption); G1 symmetric; no preemption when the other port is idle.
REQ-020 last SHALL update to the granted port on every transition into G0 or G1.
REQ-021 Grant latency: request seen on edge N in IDLE -> gnt high after edge N, first memory command issued in cycle N+1.
REQ-022 G0: mem_cmd/mem_addr/mem_wdata SHALL follow cmd0/addr0/wdata0 combinationally; G1 likewise from port 1.
REQ-023 IDLE: mem_cmd=001, mem_addr=0, mem_wdata=0.
REQ-024 A granted cmd not in {001,010,100} SHALL be driven as mem_cmd=001 and SHALL set err_illegal at next edge.
REQ-025 err_illegal SHALL stay 1 until reset; cmd from a non-granted port SHALL never reach memory nor set err_illegal.
REQ-026 A requester SHALL treat gnt deassertion as loss of ownership; arbiter does not buffer or replay the preempted command.
REQ-027 Read data return is not routed by this block; RAM read data goes to all ports in parallel, each port qualifies it with its own gnt.

Reset
REQ-028 reset==0 SHALL asynchronously set state=IDLE, last=1, counter=0, err_illegal=0; hence gnt0=gnt1=0, mem_cmd=001, mem_addr=0, mem_wdata=0.
REQ-029 Reset mid-grant SHALL drop gnt and force mem_cmd=001 in the same cycle; after release, first tie goes to port 0.
REQ-030 Requests held through reset release SHALL be arbitrated normally at the first posedge with reset==1.

Verification
REQ-031 Reset release, req0=req1=1 same cycle -> gnt0=1 after first edge, mem_cmd=cmd0, gnt1=0.
REQ-032 req0 held, cmd0=010, addr0=9'h05, req1=0 for 20 cycles -> gnt0 stays 1, mem_addr=9'h05, no preemption.
REQ-033 MAXHOLD=8, both held continuously -> gnt alternates G0 8 cycles, G1 8 cycles, with no IDLE cycle between.
REQ-034 In G1, port 1 drops req1 while req0=1 -> next cycle gnt0=1, gnt1=0, mem_cmd=cmd0.
REQ-035 Granted port drives cmd=011 -> mem_cmd=001 that cycle, err_illegal=1 next edge and stays 1; non-granted cmd=111 -> err_illegal unchanged.
REQ-036 reset pulled low mid-G0 with cmd0=100 -> mem_cmd=001, gnt0=0 without a clock edge.
